uart_alu_cmd: RTL

- Command engine directly downstream of the UART receive FIFO and upstream of the UART transmit FIFO.
- Pops three bytes from the UART: operand A, operand B, then the opcode.
- Executes the operation on an 8-bit ALU and pushes the 1-byte result back into the UART TX FIFO.
- Connects to the UART's rd_uart/r_data/rx_empty and wr_uart/w_data/tx_full ports with no glue logic.

---
 rtl/uart_alu_cmd_pkg.sv | 24 ++
 rtl/uart_alu_cmd_if.sv | 23 ++
 rtl/uart_alu_cmd_alu.sv | 32 +++
 rtl/uart_alu_cmd.sv | 96 +++++++++
 4 files changed

// File: rtl/uart_alu_cmd_pkg.sv
// Shared constants for the UART-driven ALU command engine: widths, opcodes, FSM states.
package uart_alu_cmd_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        ST_GET_A  = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SEND   = 3'd4
    } state_e;

endpackage

// File: rtl/uart_alu_cmd_if.sv
// UART FIFO-side handshake bundle: RX pop port and TX push port.
interface uart_alu_cmd_if
    import uart_alu_cmd_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF
);
    logic               rx_empty;
    logic [NB_DATA-1:0] r_data;
    logic               tx_full;
    logic               rd_uart;
    logic               wr_uart;
    logic [NB_DATA-1:0] w_data;

    modport master (
        input  rx_empty, r_data, tx_full,
        output rd_uart, wr_uart, w_data
    );

    modport slave (
        output rx_empty, r_data, tx_full,
        input  rd_uart, wr_uart, w_data
    );
endinterface

// File: rtl/uart_alu_cmd_alu.sv
// Combinational 8-bit ALU; unknown opcodes yield zero and raise err.
module alu
    import uart_alu_cmd_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic [NB_DATA-1:0] a,
    input  logic [NB_DATA-1:0] b,
    input  logic [NB_OP-1:0]   op,
    output logic [NB_DATA-1:0] out,
    output logic               err
);

    always_comb begin
        out = '0;
        err = 1'b0;
        case (op)
            OP_ADD:  out = a + b;
            OP_SUB:  out = a - b;
            OP_AND:  out = a & b;
            OP_OR:   out = a | b;
            OP_XOR:  out = a ^ b;
            OP_NOR:  out = ~(a | b);
            // Shift amount is the whole of b, so large shifts saturate naturally.
            OP_SRA:  out = $signed(a) >>> b;
            OP_SRL:  out = a >> b;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_alu_cmd.sv
// Command engine: pops A, B, opcode from the UART RX FIFO, pushes one ALU result byte to TX.
module uart_alu_cmd
    import uart_alu_cmd_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
) (
    input  logic               clk,
    input  logic               reset,
    uart_alu_cmd_if.master     uart,
    output logic [NB_DATA-1:0] result,
    output logic               op_err
);

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] reg_a_q, reg_a_d;
    logic [NB_DATA-1:0] reg_b_q, reg_b_d;
    logic [NB_OP-1:0]   reg_op_q, reg_op_d;
    logic [NB_DATA-1:0] result_q, result_d;
    logic               op_err_q, op_err_d;
    logic [NB_DATA-1:0] alu_out;
    logic               alu_err;
    logic               rd_uart, wr_uart;

    alu #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_alu (
        .a   (reg_a_q),
        .b   (reg_b_q),
        .op  (reg_op_q),
        .out (alu_out),
        .err (alu_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_GET_A;
            reg_a_q  <= '0;
            reg_b_q  <= '0;
            reg_op_q <= '0;
            result_q <= '0;
            op_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            reg_op_q <= reg_op_d;
            result_q <= result_d;
            op_err_q <= op_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        reg_a_d  = reg_a_q;
        reg_b_d  = reg_b_q;
        reg_op_d = reg_op_q;
        result_d = result_q;
        op_err_d = op_err_q;
        rd_uart  = 1'b0;
        wr_uart  = 1'b0;
        case (state_q)
            ST_GET_A: if (!uart.rx_empty) begin
                rd_uart = 1'b1;
                reg_a_d = uart.r_data;
                state_d = ST_GET_B;
            end
            ST_GET_B: if (!uart.rx_empty) begin
                rd_uart = 1'b1;
                reg_b_d = uart.r_data;
                state_d = ST_GET_OP;
            end
            ST_GET_OP: if (!uart.rx_empty) begin
                rd_uart  = 1'b1;
                reg_op_d = uart.r_data[NB_OP-1:0];
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_out;
                op_err_d = alu_err;
                state_d  = ST_SEND;
            end
            ST_SEND: if (!uart.tx_full) begin
                wr_uart = 1'b1;
                state_d = ST_GET_A;
            end
            default: state_d = ST_GET_A;
        endcase
    end

    // Strobes drop the moment reset asserts, even with data already waiting in RX.
    assign uart.rd_uart = rd_uart & reset;
    assign uart.wr_uart = wr_uart & reset;
    assign uart.w_data  = result_q;
    assign result       = result_q;
    assign op_err       = op_err_q;

endmodule
